// File: rtl/fifo_burst_reader.sv
// Read side of the sync FIFO: pops a burst of `len` words and streams them out
// through a 2-entry buffer that hides the FIFO's one-cycle read latency.
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   input  logic                  fifo_empty,
   output logic                  fifo_r_en,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [LEN_WIDTH-1:0]  issue_left;
   logic [LEN_WIDTH-1:0]  deliver_left;
   logic                  inflight;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] slot0;
   logic [DATA_WIDTH-1:0] slot1;
   logic                  pop;
   logic [2:0]            pending;
   logic                  load;
   logic                  done_next;

   assign m_valid = (occ != 2'd0);
   assign pop     = m_valid && m_ready;
   assign m_data  = slot0;
   assign m_last  = m_valid && (deliver_left == LEN_WIDTH'(1));
   assign busy    = (state != ST_IDLE);

   // Words already committed to the buffer once this cycle's pop is accounted for.
   assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      fifo_r_en  = 1'b0;
      load       = 1'b0;
      done_next  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  load       = 1'b1;
                  state_next = ST_RUN;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         ST_RUN: begin
            fifo_r_en = !fifo_empty && (issue_left != '0) && (pending < 3'd2);
            if (fifo_r_en && (issue_left == LEN_WIDTH'(1))) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && (deliver_left == LEN_WIDTH'(1))) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_left   <= '0;
         deliver_left <= '0;
      end else if (load) begin
         issue_left   <= len;
         deliver_left <= len;
      end else begin
         if (fifo_r_en) begin
            issue_left <= issue_left - LEN_WIDTH'(1);
         end
         if (pop && (deliver_left != '0)) begin
            deliver_left <= deliver_left - LEN_WIDTH'(1);
         end
      end
   end

   // slot0 is always the head; a capture lands behind whatever survives the pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         slot0    <= '0;
         slot1    <= '0;
      end else begin
         inflight <= fifo_r_en;
         case ({inflight, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  slot0 <= fifo_rdata;
               end else begin
                  slot1 <= fifo_rdata;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  slot0 <= slot1;
                  slot1 <= fifo_rdata;
               end else begin
                  slot0 <= fifo_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
